// File: rtl/uart.sv
// Full-duplex UART: parallel-load transmitter and oversampling-free receiver,
// both paced by a fixed FREQUENCY/BAUDRATE clock divider.
module uart #(
    parameter int WORD_LENGHT = 8,
    parameter int FREQUENCY   = 10,
    parameter int BAUDRATE    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Rx_in,
    input  logic [WORD_LENGHT-1:0] Tx_in,
    input  logic                   send,
    output logic                   Tx_out,
    output logic                   Tx_ready,
    output logic [WORD_LENGHT-1:0] Rx_out,
    output logic                   Rx_valid,
    output logic                   Rx_error
);

    localparam int DIV  = FREQUENCY / BAUDRATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = (WORD_LENGHT > 1) ? $clog2(WORD_LENGHT) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_LENGHT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- transmitter ----------------
    state_t                 tx_state;
    logic [CW-1:0]          tx_cnt;
    logic [BW-1:0]          tx_bit;
    logic [WORD_LENGHT-1:0] tx_shreg;

    // NOTE: all state uses non-blocking assignments so every register in this
    // block updates from the same pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            Tx_out   <= 1'b1;
            Tx_ready <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (send) begin
                        tx_shreg <= Tx_in;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        Tx_out   <= 1'b0;
                        Tx_ready <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        Tx_out   <= tx_shreg[0];
                        tx_shreg <= tx_shreg >> 1;
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == BIT_LAST) begin
                            Tx_out   <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            Tx_out   <= tx_shreg[0];
                            tx_shreg <= tx_shreg >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Ready rises here, so a held send restarts on the very next edge.
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        Tx_ready <= 1'b1;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic [1:0]             rx_sync;
    logic                   rx_s;
    state_t                 rx_state;
    logic [CW-1:0]          rx_cnt;
    logic [BW-1:0]          rx_bit;
    logic [WORD_LENGHT-1:0] rx_shreg;
    logic [WORD_LENGHT-1:0] rx_next;
    logic                   rx_wait_high;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], Rx_in};
    end

    assign rx_s = rx_sync[1];

    // NOTE: rx_next is assigned a full default first so the block stays
    // combinational instead of inferring a latch.
    always_comb begin
        rx_next                = rx_shreg >> 1;
        rx_next[WORD_LENGHT-1] = rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shreg     <= '0;
            rx_wait_high <= 1'b0;
            Rx_out       <= '0;
            Rx_valid     <= 1'b0;
            Rx_error     <= 1'b0;
        end else begin
            Rx_valid <= 1'b0;
            Rx_error <= 1'b0;
            case (rx_state)
                IDLE: begin
                    // After a framing error, a break line must go high before re-arming.
                    if (rx_wait_high) begin
                        if (rx_s) rx_wait_high <= 1'b0;
                    end else if (!rx_s) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= rx_next;
                        if (rx_bit == BIT_LAST) rx_state <= STOP;
                        else                    rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        if (rx_s) begin
                            Rx_out   <= rx_shreg;
                            Rx_valid <= 1'b1;
                        end else begin
                            Rx_error     <= 1'b1;
                            rx_wait_high <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: directed steps with random words, checked
// against a frame-level model of the serial line and a loopback word queue.
module tb_uart;

    localparam int W     = 8;
    localparam int FREQ  = 10;
    localparam int BAUD  = 1;
    localparam int DIV   = FREQ / BAUD;
    localparam int FRAME = (W + 2) * DIV;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_drv;
    logic         loop_en;
    logic         rx_line;
    logic         send;
    logic [W-1:0] tx_in;
    logic         tx_out;
    logic         tx_ready;
    logic [W-1:0] rx_out;
    logic         rx_valid;
    logic         rx_error;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_error = 0;

    assign rx_line = loop_en ? tx_out : rx_drv;

    uart #(.WORD_LENGHT(W), .FREQUENCY(FREQ), .BAUDRATE(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .Rx_in   (rx_line),
        .Tx_in   (tx_in),
        .send    (send),
        .Tx_out  (tx_out),
        .Tx_ready(tx_ready),
        .Rx_out  (rx_out),
        .Rx_valid(rx_valid),
        .Rx_error(rx_error)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) n_valid++;
        if (rx_error === 1'b1) n_error++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level during bit slot 'slot' of an 8N1-style frame carrying w.
    function automatic logic tx_level(input logic [W-1:0] w, input int slot);
        if (slot == 0)      return 1'b0;
        else if (slot <= W) return w[slot-1];
        else                return 1'b1;
    endfunction

    // Present w with send for exactly one accepting edge; returns at the
    // negedge just after that edge.
    task automatic start_frame(input logic [W-1:0] w);
        tx_in = w;
        send  = 1'b1;
        @(negedge clk);
        send  = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; checks every cycle.
    task automatic run_frame(input logic [W-1:0] w);
        for (int k = 0; k < FRAME; k++) begin
            check($sformatf("tx_out w=%0h cyc=%0d", w, k), {31'd0, tx_out}, {31'd0, tx_level(w, k / DIV)});
            check($sformatf("tx_ready busy cyc=%0d", k), {31'd0, tx_ready}, 32'd0);
            @(negedge clk);
        end
        check("tx_ready after frame", {31'd0, tx_ready}, 32'd1);
        check("tx_out after frame", {31'd0, tx_out}, 32'd1);
    endtask

    logic [W-1:0] words [6];
    logic [W-1:0] w;
    int v0, e0;

    initial begin
        rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0; send = 1'b0; tx_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and quiet idle.
        check("reset tx_out", {31'd0, tx_out}, 32'd1);
        check("reset tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset rx_out", {24'd0, rx_out}, 32'd0);
        check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset rx_error", {31'd0, rx_error}, 32'd0);
        repeat (30) @(negedge clk);
        check("idle tx_out", {31'd0, tx_out}, 32'd1);
        check("idle tx_ready", {31'd0, tx_ready}, 32'd1);
        check("idle valid count", n_valid, 32'd0);
        check("idle error count", n_error, 32'd0);

        // Single frame of 0x64.
        start_frame(8'h64);
        run_frame(8'h64);
        repeat (5) @(negedge clk);

        // send held high, Tx_in changed while busy: back-to-back frames.
        tx_in = 8'h64;
        send  = 1'b1;
        @(negedge clk);
        tx_in = 8'h73;
        run_frame(8'h64);
        @(negedge clk);
        send = 1'b0;
        run_frame(8'h73);
        repeat (5) @(negedge clk);

        // Loopback, fixed corner words followed by random ones.
        loop_en  = 1'b1;
        words[0] = 8'h00;
        words[1] = 8'hFF;
        words[2] = 8'hA5;
        for (int i = 3; i < 6; i++) words[i] = W'($urandom);
        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            e0 = n_error;
            start_frame(words[i]);
            run_frame(words[i]);
            repeat (5) @(negedge clk);
            check($sformatf("loop rx_out #%0d", i), {24'd0, rx_out}, {24'd0, words[i]});
            check($sformatf("loop valid pulses #%0d", i), n_valid - v0, 32'd1);
            check($sformatf("loop error pulses #%0d", i), n_error - e0, 32'd0);
        end

        // Reset at clock 40 of a frame aborts both directions.
        v0 = n_valid;
        e0 = n_error;
        w  = W'($urandom);
        start_frame(w);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst tx_out", {31'd0, tx_out}, 32'd1);
        check("midrst tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst rx_out", {24'd0, rx_out}, 32'd0);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("midrst no valid", n_valid - v0, 32'd0);
        check("midrst no error", n_error - e0, 32'd0);
        w = W'($urandom);
        start_frame(w);
        run_frame(w);
        repeat (5) @(negedge clk);
        check("post-rst rx_out", {24'd0, rx_out}, {24'd0, w});
        check("post-rst valid", n_valid - v0, 32'd1);
        check("post-rst error", n_error - e0, 32'd0);

        // Short glitch is rejected; a stuck-low line gives exactly one error.
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rerst rx_out", {24'd0, rx_out}, 32'd0);
        v0 = n_valid;
        e0 = n_error;
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch no valid", n_valid - v0, 32'd0);
        check("glitch no error", n_error - e0, 32'd0);
        rx_drv = 1'b0;
        repeat (400) @(negedge clk);
        check("break error count", n_error - e0, 32'd1);
        check("break valid count", n_valid - v0, 32'd0);
        check("break rx_out", {24'd0, rx_out}, 32'd0);

        // Line released: receiver recovers for a normal frame.
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        loop_en = 1'b1;
        v0 = n_valid;
        e0 = n_error;
        w  = W'($urandom);
        start_frame(w);
        run_frame(w);
        repeat (5) @(negedge clk);
        check("recover rx_out", {24'd0, rx_out}, {24'd0, w});
        check("recover valid", n_valid - v0, 32'd1);
        check("recover error", n_error - e0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
